// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial sequencer driving one external 1-bit full adder, LSB first.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_r;
  logic [CW-1:0]    cnt;

  // The adder only sees operand bits while shifting; otherwise its inputs are quiet.
  assign fa_x   = (state == SHIFT) && a_sh[0];
  assign fa_y   = (state == SHIFT) && b_sh[0];
  assign fa_cin = (state == SHIFT) && carry_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= c_in;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
          carry_r <= fa_cout;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {fa_s, sum_sh[WIDTH-1:1]};
            c_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry_r here is the carry into the MSB position.
            ovf   <= carry_r ^ fa_cout;
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed scoreboard bench for serial_adder_ctrl with a behavioural full adder.
// Build with SERIAL_ADD_OVF_EN defined to also check ovf.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         fa_x;
  logic         fa_y;
  logic         fa_cin;
  logic         fa_s;
  logic         fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // External full adder.
  assign fa_s    = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_cin & (fa_x ^ fa_y));

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .c_out   (c_out),
    .fa_x    (fa_x),
    .fa_y    (fa_y),
    .fa_cin  (fa_cin),
    .fa_s    (fa_s),
    .fa_cout (fa_cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " fa_x"}, 32'(fa_x), 32'd0);
    chk({tag, " fa_y"}, 32'(fa_y), 32'd0);
    chk({tag, " fa_cin"}, 32'(fa_cin), 32'd0);
  endtask

  // Starts one add from IDLE, monitors the fa_* bus while shifting and scores the result.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input bit hold);
    exp_t       e;
    logic [W:0] full;
    logic [W-1:0] low;
    logic       carry;
    int         lat;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    low  = {1'b0, av[W-2:0]} + {1'b0, bv[W-2:0]} + {{(W-1){1'b0}}, cv};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = low[W-1] ^ full[W];
    a = av;
    b = bv;
    c_in = cv;
    start = 1'b1;
    sb.push_back(e);
    tick();
    if (!hold) start = 1'b0;
    carry = cv;
    lat = 0;
    while (done !== 1'b1 && lat < W + 4) begin
      chk("busy_shift", 32'(busy), 32'd1);
      if (lat < W) begin
        chk("fa_x_bit", 32'(fa_x), 32'(av[lat]));
        chk("fa_y_bit", 32'(fa_y), 32'(bv[lat]));
        chk("fa_cin_bit", 32'(fa_cin), 32'(carry));
        carry = (av[lat] & bv[lat]) | (carry & (av[lat] ^ bv[lat]));
      end
      if (hold && lat == 3) begin
        a = ~av;
        b = 8'h33;
        c_in = ~cv;
      end
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk_idle_bus("done_state");
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", 32'(sum), 32'(e.s));
      chk("c_out", 32'(c_out), 32'(e.c));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 32'(ovf), 32'(e.v));
`endif
    end
    tick();
    chk("done_low", 32'(done), 32'd0);
    chk("busy_low", 32'(busy), 32'd0);
    chk("sum_held", 32'(sum), 32'(e.s));
    chk_idle_bus("idle");
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk_idle_bus("rst");
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_no_start", 32'(busy), 32'd0);

    run_add(8'h35, 8'h4A, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 1'b0);
    run_add(8'h00, 8'h00, 1'b1, 1'b0);

    // start stays high and operands move mid-add; the next accept waits for IDLE.
    run_add(8'h10, 8'h20, 1'b0, 1'b1);
    run_add(8'h01, 8'h02, 1'b0, 1'b0);

    // Reset four cycles into an add discards it.
    a = 8'h55;
    b = 8'h0F;
    c_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_c_out", 32'(c_out), 32'd0);
    chk_idle_bus("mid_rst");
    repeat (2) begin
      tick();
      chk("rst_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_add(8'h0F, 8'h01, 1'b0, 1'b0);

    run_add(8'hA5, 8'h5A, 1'b0, 1'b0);
    run_add(8'h7F, 8'h01, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 1'b0);
    run_add(8'h80, 8'h80, 1'b1, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
